// File: rtl/key_search_pkg.sv
// rtl/key_search_pkg.sv - shared types and constants for the RC4 key-space search
// Contents: ks_state_t scheduler states, default key width, ASCII bounds used by
// the message checker cores, and a byte classifier helper for those cores.
package key_search_pkg;

    localparam int KEY_WIDTH_DEFAULT = 24;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_Z     = 8'h7A;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_RUN,
        KS_DRAIN,
        KS_FOUND,
        KS_EXHAUSTED
    } ks_state_t;

    // A plaintext byte is acceptable if it is a lowercase letter or a space.
    function automatic logic is_msg_byte(input logic [7:0] c);
        return (c == ASCII_SPACE) || ((c >= ASCII_A) && (c <= ASCII_Z));
    endfunction

endpackage

// File: rtl/key_search_scheduler_if.sv
// rtl/key_search_scheduler_if.sv - scheduler <-> core array handshake bundle
// Signals: core_start (per-core dispatch pulse), core_key (flattened keys, core i
// in [i*KEY_WIDTH +: KEY_WIDTH]), core_abort (broadcast stop), core_done/core_pass
// (per-core verdict pulse and result). master = scheduler, slave = core array.
interface key_search_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = key_search_pkg::KEY_WIDTH_DEFAULT
);
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic                           core_abort;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES-1:0]           core_pass;

    modport master (
        output core_start, core_key, core_abort,
        input  core_done, core_pass
    );

    modport slave (
        input  core_start, core_key, core_abort,
        output core_done, core_pass
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter picking at most one requester per cycle
// Ports: clk, reset (sync, active-high), req (request mask), advance (grant was
// used; move priority past it), grant (one-hot), valid (some request granted).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    int            best_d;

    // Winner is the requester with the smallest cyclic distance from ptr.
    always_comb begin
        best_d = N;
        gidx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + N - int'(ptr)) % N) < best_d)) begin
                best_d = (i + N - int'(ptr)) % N;
                gidx   = PW'(i);
            end
        end
        valid = (best_d < N);
        grant = '0;
        if (valid) begin
            grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && valid) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// rtl/key_search_scheduler.sv - hands RC4 key candidates to parallel check cores
// Ports: clk, reset (sync, active-high), start (level, launches on rising edge),
// core_if (master side of the core handshake bundle), busy/found/exhausted
// (state flags), found_key (winning key while found), keys_done (verdict count).
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    key_search_scheduler_if.master      core_if,
    output logic                        busy,
    output logic                        found,
    output logic                        exhausted,
    output logic [KEY_WIDTH-1:0]        found_key,
    output logic [KEY_WIDTH:0]          keys_done
);
    localparam logic [KEY_WIDTH+1:0] KD_MAX = {2'b00, KEY_MAX} + 1'b1;

    ks_state_t                             state, state_n;
    logic                                  start_q;
    logic [KEY_WIDTH:0]                    next_key, next_key_n;
    logic [NUM_CORES-1:0]                  core_busy, core_busy_n;
    logic [NUM_CORES-1:0]                  core_start_r, core_start_n;
    logic [NUM_CORES-1:0][KEY_WIDTH-1:0]   core_key_r, core_key_n;
    logic                                  core_abort_r, core_abort_n;
    logic [KEY_WIDTH-1:0]                  found_key_r, found_key_n;
    logic [KEY_WIDTH:0]                    keys_done_r, keys_done_n;

    logic [NUM_CORES-1:0]                  valid_done, pass_vec, grant;
    logic                                  grant_valid, dispatch;
    logic [KEY_WIDTH-1:0]                  win_key;
    logic [KEY_WIDTH+1:0]                  kd_sum;

    // The arbiter sees the registered busy mask, so a core freed this cycle
    // cannot be re-granted until the next one.
    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (~core_busy),
        .advance (dispatch),
        .grant   (grant),
        .valid   (grant_valid)
    );

    always_comb begin
        state_n      = state;
        next_key_n   = next_key;
        core_busy_n  = core_busy;
        core_start_n = '0;
        core_key_n   = core_key_r;
        core_abort_n = 1'b0;
        found_key_n  = found_key_r;
        keys_done_n  = keys_done_r;
        dispatch     = 1'b0;
        kd_sum       = '0;
        win_key      = '0;

        // Verdicts from cores we did not dispatch to are dropped here.
        valid_done = core_if.core_done & core_busy;
        pass_vec   = valid_done & core_if.core_pass;
        // Descending scan so the lowest passing core index wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pass_vec[i]) begin
                win_key = core_key_r[i];
            end
        end

        case (state)
            KS_IDLE, KS_FOUND, KS_EXHAUSTED: begin
                if (start && !start_q) begin
                    next_key_n  = '0;
                    keys_done_n = '0;
                    core_busy_n = '0;
                    if (state == KS_FOUND) begin
                        found_key_n = '0;
                    end
                    state_n = KS_RUN;
                end
            end
            KS_RUN, KS_DRAIN: begin
                kd_sum      = {1'b0, keys_done_r} + (KEY_WIDTH+2)'($countones(valid_done));
                keys_done_n = (kd_sum > KD_MAX) ? KD_MAX[KEY_WIDTH:0] : kd_sum[KEY_WIDTH:0];
                core_busy_n = core_busy & ~valid_done;
                if (|pass_vec) begin
                    // A pass pre-empts any dispatch in the same cycle.
                    found_key_n  = win_key;
                    core_abort_n = 1'b1;
                    core_busy_n  = '0;
                    state_n      = KS_FOUND;
                end else if ((state == KS_RUN) && grant_valid) begin
                    dispatch     = 1'b1;
                    core_start_n = grant;
                    core_busy_n  = core_busy_n | grant;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (grant[i]) begin
                            core_key_n[i] = next_key[KEY_WIDTH-1:0];
                        end
                    end
                    next_key_n = next_key + 1'b1;
                    if (next_key == {1'b0, KEY_MAX}) begin
                        state_n = KS_DRAIN;
                    end
                end else if ((state == KS_DRAIN) && (core_busy_n == '0)) begin
                    state_n = KS_EXHAUSTED;
                end
            end
            default: state_n = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= KS_IDLE;
            start_q      <= 1'b0;
            next_key     <= '0;
            core_busy    <= '0;
            core_start_r <= '0;
            core_key_r   <= '0;
            core_abort_r <= 1'b0;
            found_key_r  <= '0;
            keys_done_r  <= '0;
        end else begin
            state        <= state_n;
            start_q      <= start;
            next_key     <= next_key_n;
            core_busy    <= core_busy_n;
            core_start_r <= core_start_n;
            core_key_r   <= core_key_n;
            core_abort_r <= core_abort_n;
            found_key_r  <= found_key_n;
            keys_done_r  <= keys_done_n;
        end
    end

    assign core_if.core_start = core_start_r;
    assign core_if.core_key   = core_key_r;
    assign core_if.core_abort = core_abort_r;
    assign busy      = (state == KS_RUN) || (state == KS_DRAIN);
    assign found     = (state == KS_FOUND);
    assign exhausted = (state == KS_EXHAUSTED);
    assign found_key = found_key_r;
    assign keys_done = keys_done_r;

endmodule

// File: tb/tb_key_search_scheduler.sv
// tb/tb_key_search_scheduler.sv - self-checking bench for key_search_scheduler
module tb_key_search_scheduler;
    localparam int NC   = 2;
    localparam int KW   = 24;
    localparam int KMAX = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, found, exhausted;
    logic [KW-1:0] found_key;
    logic [KW:0]   keys_done;

    key_search_scheduler_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) ksif ();

    key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(24'd7)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .core_if   (ksif),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .found_key (found_key),
        .keys_done (keys_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Core array model: each dispatched key completes after a fixed latency
    // (one extra cycle for slow_key); pass_mask marks which keys decrypt cleanly.
    logic [7:0]    pass_mask = 8'h00;
    int            slow_key = -1;
    bit            clear_req = 1'b0;
    logic [NC-1:0] spur_mask = '0;
    int            cnt [NC];
    int            ckey [NC];
    int            keys_q [$];
    int            start_count = 0, abort_count = 0, starts_after_pass = 0, done_total = 0;
    bit            after_pass = 1'b0, exp_valid = 1'b0;
    int            exp_found = 0;
    logic [NC-1:0] dv, pv;

    always @(negedge clk) begin
        dv = '0;
        pv = '0;
        if (reset || clear_req) begin
            for (int i = 0; i < NC; i++) cnt[i] = 0;
            keys_q.delete();
            start_count = 0; abort_count = 0; starts_after_pass = 0; done_total = 0;
            after_pass = 1'b0; exp_valid = 1'b0; exp_found = 0;
        end else begin
            if (ksif.core_abort) begin
                abort_count++;
                after_pass = 1'b1;
                for (int i = 0; i < NC; i++) cnt[i] = 0;
            end
            for (int i = 0; i < NC; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        dv[i] = 1'b1;
                        pv[i] = pass_mask[ckey[i][2:0]];
                        done_total++;
                    end
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (pv[i] && !exp_valid) begin
                    exp_found = ckey[i];
                    exp_valid = 1'b1;
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (ksif.core_start[i]) begin
                    int k;
                    k = int'(ksif.core_key[i*KW +: KW]);
                    keys_q.push_back(k);
                    start_count++;
                    if (after_pass) starts_after_pass++;
                    ckey[i] = k;
                    cnt[i]  = (k == slow_key) ? 4 : 3;
                end
            end
        end
        ksif.core_done = dv | spur_mask;
        ksif.core_pass = pv | spur_mask;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] pm, input int slow);
        pass_mask = pm;
        slow_key  = slow;
        start     = 1'b0;
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        start     = 1'b1;
    endtask

    task automatic wait_end(input bit pulse, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (pulse && n == 4) start = 1'b0;
            if (pulse && n == 6) start = 1'b1;
            cyc();
            if (found || exhausted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_order(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < keys_q.size(); i++) begin
            if (keys_q[i] != i) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    task automatic spurious(input logic [NC-1:0] m, input string tag);
        int kd;
        bit f, e;
        kd = int'(keys_done);
        f  = found;
        e  = exhausted;
        spur_mask = m;
        cyc();
        spur_mask = '0;
        repeat (2) cyc();
        check_eq({tag, "_keys_done"}, int'(keys_done), kd);
        check_eq({tag, "_state"}, int'({found, exhausted, busy}), int'({f, e, 1'b0}));
    endtask

    initial begin
        bit ok;
        int n;

        repeat (3) cyc();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_found", int'(found), 0);
        check_eq("rst_exhausted", int'(exhausted), 0);
        check_eq("rst_found_key", int'(found_key), 0);
        check_eq("rst_keys_done", int'(keys_done), 0);
        check_eq("rst_core_start", int'(ksif.core_start), 0);
        check_eq("rst_core_abort", int'(ksif.core_abort), 0);
        reset = 1'b0;
        cyc();
        spurious(2'b01, "spur_idle");

        // Pass at key 5.
        launch(8'h20, -1);
        wait_end(1'b0, ok);
        check_eq("pass5_done", int'(ok), 1);
        check_eq("pass5_found", int'(found), 1);
        check_eq("pass5_found_key", int'(found_key), 5);
        check_eq("pass5_keys_done", int'(keys_done), done_total);
        repeat (8) cyc();
        check_eq("pass5_abort_count", abort_count, 1);
        check_eq("pass5_late_starts", starts_after_pass, 0);
        check_eq("pass5_still_found", int'(found), 1);
        check_order("pass5_order");
        spurious(2'b10, "spur_found");

        // All keys fail; launched from FOUND so found_key must clear.
        launch(8'h00, -1);
        cyc();
        check_eq("fail_found_key_cleared", int'(found_key), 0);
        check_eq("fail_busy", int'(busy), 1);
        wait_end(1'b0, ok);
        check_eq("fail_done", int'(ok), 1);
        check_eq("fail_exhausted", int'(exhausted), 1);
        check_eq("fail_found", int'(found), 0);
        check_eq("fail_starts", start_count, KMAX + 1);
        check_eq("fail_keys_done", int'(keys_done), KMAX + 1);
        check_eq("fail_model_dones", done_total, KMAX + 1);
        check_order("fail_order");

        // Restart from EXHAUSTED with a start toggle during RUN.
        launch(8'h00, -1);
        wait_end(1'b1, ok);
        check_eq("mid_start_done", int'(ok), 1);
        check_eq("mid_start_count", start_count, KMAX + 1);
        check_order("mid_start_order");
        check_eq("mid_start_found_key", int'(found_key), 0);
        check_eq("mid_start_exhausted", int'(exhausted), 1);

        // Two passes land together; lower core index wins.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        launch(8'h0C, 2);
        wait_end(1'b0, ok);
        check_eq("dual_done", int'(ok), 1);
        check_eq("dual_found_key", int'(found_key), exp_found);
        check_eq("dual_model_valid", int'(exp_valid), 1);
        check_eq("dual_keys_done", int'(keys_done), done_total);
        repeat (4) cyc();
        check_eq("dual_abort_count", abort_count, 1);

        // Reset while draining, then a fresh search.
        launch(8'h00, -1);
        n = 0;
        while (start_count < KMAX + 1 && n < 200) begin
            cyc();
            n++;
        end
        check_eq("drain_reached", int'(start_count == KMAX + 1), 1);
        reset = 1'b1;
        cyc();
        check_eq("drain_rst_busy", int'(busy), 0);
        check_eq("drain_rst_flags", int'({found, exhausted}), 0);
        check_eq("drain_rst_keys_done", int'(keys_done), 0);
        check_eq("drain_rst_outputs", int'({ksif.core_start, ksif.core_abort}), 0);
        reset = 1'b0;
        launch(8'h00, -1);
        n = 0;
        while (start_count == 0 && n < 50) begin
            cyc();
            n++;
        end
        check_eq("relaunch_latency", n, 2);
        check_eq("relaunch_first_key", (keys_q.size() > 0) ? keys_q[0] : -1, 0);
        wait_end(1'b0, ok);
        check_eq("relaunch_exhausted", int'(exhausted), 1);
        check_order("relaunch_order");
        start = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
